// File: rtl/mult_seq_ctrl.sv
// Job sequencer for the 1-D multiplier-switch array: stationary load,
// streaming issue, then result drain with timeout.
module mult_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_load,
    input  logic [CNT_W-1:0] i_num_stream,
    input  logic             i_up_valid,
    output logic             o_up_ready,
    output logic             o_mult_valid,
    output logic             o_mult_stationary,
    input  logic             i_mult_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_result_cnt
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_num_load;
    logic [CNT_W-1:0] r_num_stream;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_stream_cnt;
    logic [CNT_W-1:0] r_result_cnt;
    logic [IW-1:0]    r_idle_cnt;
    logic             r_done;
    logic             r_err;

    logic             w_xfer;
    logic             w_count_res;
    logic             w_last_load;
    logic             w_last_stream;
    logic             w_drained;
    logic             w_timeout;
    logic [CNT_W-1:0] w_res_next;

    assign o_up_ready        = (r_state == S_LOAD) || (r_state == S_STREAM);
    assign w_xfer            = o_up_ready & i_up_valid;
    assign o_mult_valid      = w_xfer;
    assign o_mult_stationary = (r_state == S_LOAD) & w_xfer;
    assign o_busy            = o_up_ready || (r_state == S_DRAIN);
    assign o_done            = r_done;
    assign o_err             = r_err;
    assign o_result_cnt      = r_result_cnt;

    // Results only count once streaming has begun.
    assign w_count_res = i_mult_valid &&
                         ((r_state == S_STREAM) || (r_state == S_DRAIN));
    assign w_res_next    = r_result_cnt + CNT_W'(w_count_res);
    assign w_last_load   = (r_load_cnt == r_num_load - CNT_W'(1));
    assign w_last_stream = (r_stream_cnt == r_num_stream - CNT_W'(1));
    assign w_drained     = (r_num_stream == '0) || (w_res_next == r_num_stream);
    assign w_timeout     = !i_mult_valid && (r_idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_num_load   <= '0;
            r_num_stream <= '0;
            r_load_cnt   <= '0;
            r_stream_cnt <= '0;
            r_result_cnt <= '0;
            r_idle_cnt   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_count_res) begin
                r_result_cnt <= w_res_next;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_num_load   <= i_num_load;
                        r_num_stream <= i_num_stream;
                        r_load_cnt   <= '0;
                        r_stream_cnt <= '0;
                        r_result_cnt <= '0;
                        r_idle_cnt   <= '0;
                        r_err        <= 1'b0;
                        if (i_num_load != '0) begin
                            r_state <= S_LOAD;
                        end else if (i_num_stream != '0) begin
                            r_state <= S_STREAM;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_load_cnt <= r_load_cnt + CNT_W'(1);
                        if (w_last_load) begin
                            r_idle_cnt <= '0;
                            r_state    <= (r_num_stream != '0) ? S_STREAM
                                                               : S_DRAIN;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_stream_cnt <= r_stream_cnt + CNT_W'(1);
                        if (w_last_stream) begin
                            r_idle_cnt <= '0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (i_mult_valid) begin
                        r_idle_cnt <= '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a small array model that
// returns one result per streamed vector.
module tb_mult_seq_ctrl;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             rst = 1'b0;
    logic             i_start = 1'b0;
    logic [CNT_W-1:0] i_num_load = '0;
    logic [CNT_W-1:0] i_num_stream = '0;
    logic             i_up_valid = 1'b0;
    logic             o_up_ready;
    logic             o_mult_valid;
    logic             o_mult_stationary;
    logic             i_mult_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [CNT_W-1:0] o_result_cnt;

    int n_pass = 0;
    int n_total = 0;

    mult_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .CLK              (CLK),
        .rst              (rst),
        .i_start          (i_start),
        .i_num_load       (i_num_load),
        .i_num_stream     (i_num_stream),
        .i_up_valid       (i_up_valid),
        .o_up_ready       (o_up_ready),
        .o_mult_valid     (o_mult_valid),
        .o_mult_stationary(o_mult_stationary),
        .i_mult_valid     (i_mult_valid),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_result_cnt     (o_result_cnt)
    );

    always #5 CLK = ~CLK;

    // Array model: streamed vectors come back as results, limited by a budget
    logic pipe_q  = 1'b0;
    logic arr_res = 1'b0;
    logic tb_res  = 1'b0;
    int   arr_sent = 0;
    int   arr_limit = 0;

    assign i_mult_valid = arr_res | tb_res;

    always @(negedge CLK) begin
        pipe_q <= o_mult_valid & ~o_mult_stationary;
        if (pipe_q && arr_sent < arr_limit) begin
            arr_res  <= 1'b1;
            arr_sent <= arr_sent + 1;
        end else begin
            arr_res <= 1'b0;
        end
    end

    int n_issue = 0;
    int n_stat  = 0;
    int n_done  = 0;
    int n_ready = 0;
    int n_bad   = 0;

    always @(negedge CLK) begin
        if (o_mult_valid === 1'b1) n_issue <= n_issue + 1;
        if (o_mult_stationary === 1'b1) n_stat <= n_stat + 1;
        if (o_done === 1'b1) n_done <= n_done + 1;
        if (o_up_ready === 1'b1) n_ready <= n_ready + 1;
        if (o_mult_valid !== (o_up_ready & i_up_valid)) n_bad <= n_bad + 1;
    end

    task automatic start_job(input int nl, input int ns);
        @(posedge CLK); #1;
        i_num_load   = CNT_W'(nl);
        i_num_stream = CNT_W'(ns);
        i_start      = 1'b1;
        @(posedge CLK); #1;
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max) begin
            @(negedge CLK);
            cyc++;
            if (o_done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_total++;
        if ({o_busy, o_up_ready, o_mult_valid, o_mult_stationary,
             o_done, o_err} !== 6'b0)
            $display("FAIL reset_flags got %b exp 000000",
                     {o_busy, o_up_ready, o_mult_valid, o_mult_stationary,
                      o_done, o_err});
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd0)
            $display("FAIL reset_result_cnt got %0d exp 0", o_result_cnt);
        else n_pass++;
        rst = 1'b1;
        tb_res = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tb_res = 1'b0;
        n_total++;
        if (o_result_cnt !== 16'd0)
            $display("FAIL idle_result_ignored got %0d exp 0", o_result_cnt);
        else n_pass++;
        n_total++;
        if (o_busy !== 1'b0)
            $display("FAIL idle_busy got %b exp 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        int  bi, bs, bd, cyc;
        bit  got;
        bi = n_issue; bs = n_stat; bd = n_done;
        arr_limit = arr_sent + 3;
        i_up_valid = 1'b1;
        start_job(2, 3);
        wait_done(100, cyc, got);
        n_total++;
        if (!got) $display("FAIL basic_done timeout after %0d cycles", cyc);
        else n_pass++;
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (n_issue - bi !== 5)
            $display("FAIL basic_issues got %0d exp 5", n_issue - bi);
        else n_pass++;
        n_total++;
        if (n_stat - bs !== 2)
            $display("FAIL basic_stationary got %0d exp 2", n_stat - bs);
        else n_pass++;
        n_total++;
        if (n_done - bd !== 1)
            $display("FAIL basic_done_pulses got %0d exp 1", n_done - bd);
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd3)
            $display("FAIL basic_result_cnt got %0d exp 3", o_result_cnt);
        else n_pass++;
        n_total++;
        if ({o_err, o_busy} !== 2'b00)
            $display("FAIL basic_err_busy got %b exp 00", {o_err, o_busy});
        else n_pass++;
    endtask

    task automatic test_stalls();
        int bi, bs, bd, bb;
        bit got;
        bi = n_issue; bs = n_stat; bd = n_done; bb = n_bad;
        arr_limit = arr_sent + 4;
        i_up_valid = 1'b0;
        start_job(1, 4);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge CLK); #1;
            i_up_valid = ~i_up_valid;
            @(negedge CLK);
            if (o_done === 1'b1) got = 1'b1;
        end
        n_total++;
        if (!got) $display("FAIL stall_done timeout");
        else n_pass++;
        i_up_valid = 1'b0;
        settle();
        n_total++;
        if (n_issue - bi !== 5)
            $display("FAIL stall_issues got %0d exp 5", n_issue - bi);
        else n_pass++;
        n_total++;
        if (n_stat - bs !== 1)
            $display("FAIL stall_stationary got %0d exp 1", n_stat - bs);
        else n_pass++;
        n_total++;
        if (n_bad - bb !== 0)
            $display("FAIL stall_valid_gating got %0d bad cycles exp 0",
                     n_bad - bb);
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd4 || n_done - bd !== 1)
            $display("FAIL stall_result got cnt %0d done %0d exp 4 1",
                     o_result_cnt, n_done - bd);
        else n_pass++;
    endtask

    task automatic test_zero();
        int bi, bs, br, cyc;
        bit got;
        bi = n_issue; bs = n_stat;
        arr_limit = arr_sent + 2;
        i_up_valid = 1'b1;
        start_job(0, 2);
        wait_done(100, cyc, got);
        n_total++;
        if (!got) $display("FAIL zero_load_done timeout");
        else n_pass++;
        settle();
        n_total++;
        if (n_stat - bs !== 0 || n_issue - bi !== 2)
            $display("FAIL zero_load_issues got stat %0d issue %0d exp 0 2",
                     n_stat - bs, n_issue - bi);
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd2)
            $display("FAIL zero_load_result got %0d exp 2", o_result_cnt);
        else n_pass++;
        br = n_ready; bi = n_issue;
        start_job(0, 0);
        wait_done(2, cyc, got);
        n_total++;
        if (!got) $display("FAIL zero_zero_done not within %0d cycles", cyc);
        else n_pass++;
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (n_ready - br !== 0 || n_issue - bi !== 0)
            $display("FAIL zero_zero_ready got ready %0d issue %0d exp 0 0",
                     n_ready - br, n_issue - bi);
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd0)
            $display("FAIL zero_zero_result got %0d exp 0", o_result_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bd, cyc;
        bit got;
        bd = n_done;
        arr_limit = arr_sent + 1;
        i_up_valid = 1'b1;
        start_job(0, 2);
        wait_done(200, cyc, got);
        n_total++;
        if (!got || cyc != 67)
            $display("FAIL timeout_latency got %0d (seen %0d) exp 67",
                     cyc, got);
        else n_pass++;
        settle();
        n_total++;
        if (o_err !== 1'b1)
            $display("FAIL timeout_err got %b exp 1", o_err);
        else n_pass++;
        n_total++;
        if (o_result_cnt !== 16'd1 || n_done - bd !== 1)
            $display("FAIL timeout_counts got cnt %0d done %0d exp 1 1",
                     o_result_cnt, n_done - bd);
        else n_pass++;
        arr_limit = arr_sent + 1;
        start_job(0, 1);
        n_total++;
        if ({o_err, o_busy} !== 2'b01)
            $display("FAIL timeout_err_clear got %b exp 01", {o_err, o_busy});
        else n_pass++;
        wait_done(100, cyc, got);
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (!got || o_err !== 1'b0 || o_result_cnt !== 16'd1)
            $display("FAIL timeout_next_job got done %0d err %b cnt %0d exp 1 0 1",
                     got, o_err, o_result_cnt);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int bi, bd, cyc;
        bit got;
        bi = n_issue; bd = n_done;
        arr_limit = arr_sent + 4;
        i_up_valid = 1'b1;
        start_job(1, 4);
        repeat (2) @(posedge CLK);
        #1;
        i_num_load   = 16'd5;
        i_num_stream = 16'd5;
        i_start      = 1'b1;
        @(posedge CLK); #1;
        i_start      = 1'b0;
        n_total++;
        if ({o_busy, o_up_ready, o_mult_stationary} !== 3'b110)
            $display("FAIL busy_start_state got %b exp 110",
                     {o_busy, o_up_ready, o_mult_stationary});
        else n_pass++;
        wait_done(100, cyc, got);
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (!got || n_issue - bi !== 5 || o_result_cnt !== 16'd4 ||
            n_done - bd !== 1)
            $display("FAIL busy_start_job got done %0d issue %0d cnt %0d pulses %0d exp 1 5 4 1",
                     got, n_issue - bi, o_result_cnt, n_done - bd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bi, cyc;
        bit got;
        arr_limit = arr_sent + 6;
        i_up_valid = 1'b1;
        start_job(2, 6);
        repeat (4) @(posedge CLK);
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({o_busy, o_up_ready, o_mult_valid, o_mult_stationary,
             o_done, o_err} !== 6'b0 || o_result_cnt !== 16'd0)
            $display("FAIL midreset_outputs got %b cnt %0d exp 000000 0",
                     {o_busy, o_up_ready, o_mult_valid, o_mult_stationary,
                      o_done, o_err}, o_result_cnt);
        else n_pass++;
        @(posedge CLK); #1;
        rst = 1'b1;
        i_up_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        bi = n_issue;
        arr_limit = arr_sent + 2;
        i_up_valid = 1'b1;
        start_job(1, 2);
        wait_done(100, cyc, got);
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (!got || o_result_cnt !== 16'd2 || o_err !== 1'b0 ||
            n_issue - bi !== 3)
            $display("FAIL midreset_next_job got done %0d cnt %0d err %b issue %0d exp 1 2 0 3",
                     got, o_result_cnt, o_err, n_issue - bi);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bi, bs, bd, cyc;
        bit got;
        bi = n_issue; bs = n_stat; bd = n_done;
        arr_limit = arr_sent + 2;
        i_up_valid = 1'b1;
        start_job(1, 2);
        wait_done(100, cyc, got);
        n_total++;
        if (!got) $display("FAIL b2b_first_done timeout");
        else n_pass++;
        arr_limit = arr_limit + 3;
        i_num_load   = 16'd2;
        i_num_stream = 16'd3;
        i_start      = 1'b1;
        @(posedge CLK); #1;
        i_start      = 1'b0;
        n_total++;
        if ({o_busy, o_mult_stationary} !== 2'b11 || o_result_cnt !== 16'd0)
            $display("FAIL b2b_restart got %b cnt %0d exp 11 0",
                     {o_busy, o_mult_stationary}, o_result_cnt);
        else n_pass++;
        wait_done(100, cyc, got);
        settle();
        i_up_valid = 1'b0;
        n_total++;
        if (!got || o_result_cnt !== 16'd3)
            $display("FAIL b2b_second_job got done %0d cnt %0d exp 1 3",
                     got, o_result_cnt);
        else n_pass++;
        n_total++;
        if (n_done - bd !== 2 || n_stat - bs !== 3 || n_issue - bi !== 8)
            $display("FAIL b2b_totals got done %0d stat %0d issue %0d exp 2 3 8",
                     n_done - bd, n_stat - bs, n_issue - bi);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_zero();
        test_timeout();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
